// File: rtl/alu_pkg.sv
// =============================================================================
// alu_pkg : ALU operation encodings and status flag layout
// Rev 1.0
// =============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SHL  = 4'd5,
        SHR  = 4'd6,
        MULT = 4'd7,
        DIV  = 4'd8
    } control_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } status_t;

endpackage

`default_nettype wire

// File: rtl/wb_pkg.sv
// =============================================================================
// wb_pkg : writeback FSM states and double-write operation classifier
// Rev 1.0
// =============================================================================
`default_nettype none

package wb_pkg;

    import alu_pkg::*;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_LO   = 2'd1,
        WB_HI   = 2'd2
    } wb_state_e;

    // Only MULT and DIV produce a meaningful upper half; unknown encodings fall through as single-word.
    function automatic logic is_double(input control_e c);
        return (c == MULT) || (c == DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_writeback.sv
// =============================================================================
// alu_writeback : sequences ALU results onto the register-file write port
// Rev 1.0
// =============================================================================
`default_nettype none

module alu_writeback
    import alu_pkg::*;
    import wb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int HI_REG     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_result,
    input  control_e              in_control,
    input  status_t               in_stat,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output status_t               flags_q,
    output logic                  busy
);

    wb_state_e               r_state;
    wb_state_e               w_next;
    logic [2*DATA_W-1:0]     r_result;
    control_e                r_control;
    status_t                 r_stat;
    logic [REG_ADDR_W-1:0]   r_rd;
    status_t                 r_flags;
    logic                    w_xfer;
    logic                    w_double;

    assign w_double = is_double(r_control);
    // A transfer that coincides with flush is discarded entirely.
    assign w_xfer   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WB_IDLE;
            r_result  <= '0;
            r_control <= ADD;
            r_stat    <= '0;
            r_rd      <= '0;
            r_flags   <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_result  <= in_result;
                r_control <= in_control;
                r_stat    <= in_stat;
                r_rd      <= in_rd;
            end
            if (r_state == WB_LO) begin
                r_flags <= r_stat;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b1;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (r_state)
            WB_IDLE: begin
                if (w_xfer) w_next = WB_LO;
            end
            WB_LO: begin
                rf_we    = 1'b1;
                rf_waddr = r_rd;
                rf_wdata = r_result[DATA_W-1:0];
                if (w_double) begin
                    in_ready = 1'b0;
                    w_next   = WB_HI;
                end else begin
                    w_next = w_xfer ? WB_LO : WB_IDLE;
                end
            end
            WB_HI: begin
                rf_we    = 1'b1;
                rf_waddr = REG_ADDR_W'(HI_REG);
                rf_wdata = r_result[2*DATA_W-1:DATA_W];
                w_next   = w_xfer ? WB_LO : WB_IDLE;
            end
            default: begin
                w_next = WB_IDLE;
            end
        endcase
        if (flush) w_next = WB_IDLE;
    end

    assign flags_q = r_flags;
    assign busy    = (r_state != WB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback.sv
// =============================================================================
// tb_alu_writeback : directed self-checking bench for alu_writeback
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_alu_writeback;

    import alu_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_result;
    control_e       in_control;
    status_t        in_stat;
    logic [3:0]     in_rd;
    logic           rf_we;
    logic [3:0]     rf_waddr;
    logic [15:0]    rf_wdata;
    status_t        flags_q;
    logic           busy;

    int checks = 0;
    int errors = 0;

    alu_writeback #(.DATA_W(16), .REG_ADDR_W(4), .HI_REG(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_control (in_control),
        .in_stat    (in_stat),
        .in_rd      (in_rd),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .flags_q    (flags_q),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input control_e c, input logic [31:0] r,
                         input logic [3:0] rd, input status_t s);
        in_valid   = v;
        in_control = c;
        in_result  = r;
        in_rd      = rd;
        in_stat    = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, ADD, 32'h0, 4'h0, '0);
        #7;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", rf_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        checks++; if (flags_q !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({rf_waddr, rf_wdata} !== 20'h0) begin errors++; $display("FAIL reset_port: got %h expected 00000", {rf_waddr, rf_wdata}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_add();
        status_t s;
        s = '{carry: 1'b1, zero: 1'b0, negative: 1'b0, overflow: 1'b1};
        drive(1'b1, ADD, 32'h0000_1234, 4'd3, s);
        step();
        in_valid = 1'b0;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 16'h1234}) begin errors++; $display("FAIL add_write: got %b/%h/%h expected 1/3/1234", rf_we, rf_waddr, rf_wdata); end
        checks++; if (flags_q !== 4'b0) begin errors++; $display("FAIL add_flags_early: got %b expected 0000", flags_q); end
        step();
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_idle: got we=%b busy=%b expected 0/0", rf_we, busy); end
        checks++; if (flags_q !== s) begin errors++; $display("FAIL add_flags: got %b expected %b", flags_q, s); end
    endtask

    task automatic test_mult_then_add();
        status_t s1, s2;
        s1 = '{carry: 1'b0, zero: 1'b0, negative: 1'b1, overflow: 1'b0};
        s2 = '{carry: 1'b0, zero: 1'b1, negative: 1'b0, overflow: 1'b0};
        drive(1'b1, MULT, 32'h0001_E240, 4'd5, s1);
        step();
        drive(1'b1, ADD, 32'h0000_0055, 4'd7, s2);
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd5, 16'hE240}) begin errors++; $display("FAIL mult_lo: got %b/%h/%h expected 1/5/e240", rf_we, rf_waddr, rf_wdata); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mult_ready_lo: got %b expected 0", in_ready); end
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd0, 16'h0001}) begin errors++; $display("FAIL mult_hi: got %b/%h/%h expected 1/0/0001", rf_we, rf_waddr, rf_wdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_ready_hi: got %b expected 1", in_ready); end
        checks++; if (flags_q !== s1) begin errors++; $display("FAIL mult_flags: got %b expected %b", flags_q, s1); end
        step();
        in_valid = 1'b0;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd7, 16'h0055}) begin errors++; $display("FAIL mult_next_add: got %b/%h/%h expected 1/7/0055", rf_we, rf_waddr, rf_wdata); end
        checks++; if (flags_q !== s1) begin errors++; $display("FAIL mult_flags_hold: got %b expected %b", flags_q, s1); end
        step();
        checks++; if (flags_q !== s2 || busy !== 1'b0) begin errors++; $display("FAIL mult_add_done: got flags=%b busy=%b expected %b/0", flags_q, busy, s2); end
    endtask

    task automatic test_div_rd_hi();
        drive(1'b1, DIV, 32'h0002_0007, 4'd0, '0);
        step();
        in_valid = 1'b0;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd0, 16'h0007}) begin errors++; $display("FAIL div_quot: got %b/%h/%h expected 1/0/0007", rf_we, rf_waddr, rf_wdata); end
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd0, 16'h0002}) begin errors++; $display("FAIL div_rem: got %b/%h/%h expected 1/0/0002", rf_we, rf_waddr, rf_wdata); end
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL div_idle: got %b expected 0", rf_we); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, AND, 32'h0000_00AA, 4'd1, '0);
        step();
        drive(1'b1, OR, 32'h0000_00BB, 4'd2, '0);
        checks++; if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 4'd1, 16'h00AA, 1'b1}) begin errors++; $display("FAIL b2b_and: got %b/%h/%h/%b expected 1/1/00aa/1", rf_we, rf_waddr, rf_wdata, in_ready); end
        step();
        drive(1'b1, SUB, 32'h0000_00CC, 4'd3, '0);
        checks++; if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 4'd2, 16'h00BB, 1'b1}) begin errors++; $display("FAIL b2b_or: got %b/%h/%h/%b expected 1/2/00bb/1", rf_we, rf_waddr, rf_wdata, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if ({rf_we, rf_waddr, rf_wdata, in_ready} !== {1'b1, 4'd3, 16'h00CC, 1'b1}) begin errors++; $display("FAIL b2b_sub: got %b/%h/%h/%b expected 1/3/00cc/1", rf_we, rf_waddr, rf_wdata, in_ready); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_flush();
        drive(1'b1, MULT, 32'hABCD_1111, 4'd9, '0);
        step();
        in_valid = 1'b0;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd9, 16'h1111}) begin errors++; $display("FAIL flush_lo: got %b/%h/%h expected 1/9/1111", rf_we, rf_waddr, rf_wdata); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_drop_hi: got we=%b busy=%b expected 0/0", rf_we, busy); end
        drive(1'b1, ADD, 32'h0000_4444, 4'd2, '0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_discard: got we=%b busy=%b expected 0/0", rf_we, busy); end
    endtask

    task automatic test_reset_mid_hi();
        status_t s;
        s = '{carry: 1'b1, zero: 1'b1, negative: 1'b1, overflow: 1'b1};
        drive(1'b1, MULT, 32'h1234_5678, 4'd4, s);
        step();
        in_valid = 1'b0;
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd0, 16'h1234}) begin errors++; $display("FAIL rst_pre_hi: got %b/%h/%h expected 1/0/1234", rf_we, rf_waddr, rf_wdata); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_async: got we=%b busy=%b rdy=%b expected 0/0/1", rf_we, busy, in_ready); end
        checks++; if (flags_q !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b expected 0000", flags_q); end
        #1;
        rst_n = 1'b1;
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_no_hi: got %b expected 0", rf_we); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_mult_then_add();
        test_div_rd_hi();
        test_back_to_back();
        test_flush();
        test_reset_mid_hi();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Result-side consumer of the ALU: accepts one ALU result per transaction and drives the single write port of the 16-bit register file. It sequences two writes for the 32-bit operations. For MULT, those are the low product to Rd and the high product to the hi register. For DIV, those are the quotient to Rd and the remainder to the hi register. It also holds the architectural status flags. It sits between the execute stage and the register file, and uses valid/ready to stall execute while a double write is in progress.

Parameters:
DATA_W, 16, register/data word width; ALU result is 2*DATA_W
REG_ADDR_W, 4, register file address width
HI_REG, 0, register index receiving the upper half (MULT high product / DIV remainder)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous drop of any captured, not-yet-completed transaction
in_valid  input  1  execute stage presents a result
in_ready  output  1  block can accept a result this cycle
in_result  input  2*DATA_W  ALU output word
in_control  input  alu_pkg::control_e  operation that produced in_result
in_stat  input  alu_pkg::status_t  ALU flags for that result
in_rd  input  REG_ADDR_W  destination register
rf_we  output  1  register file write enable
rf_waddr  output  REG_ADDR_W  register file write address
rf_wdata  output  DATA_W  register file write data
flags_q  output  alu_pkg::status_t  committed status flags
busy  output  1  high whenever state != WB_IDLE

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state = WB_IDLE; in_ready = 1.
  - rf_we = 0; rf_waddr = 0; rf_wdata = 0.
  - flags_q = all zero; busy = 0.
  - Capture registers are cleared.
- Handshake: a transfer occurs on a rising edge with in_valid & in_ready. All in_* fields are captured on that edge. in_ready is combinational from state only, never from in_valid.
- State WB_IDLE:
  - in_ready = 1; rf_we = 0.
  - On transfer, go to WB_LO.
- State WB_LO:
  - rf_we = 1, rf_waddr = captured rd, rf_wdata = result[DATA_W-1:0].
  - flags_q loads the captured stat on the exit edge.
  - If the captured control is MULT or DIV: in_ready = 0; next state WB_HI.
  - Otherwise: in_ready = 1. On transfer, capture the new result and stay in WB_LO (back-to-back, one write per cycle); else go to WB_IDLE.
- State WB_HI:
  - rf_we = 1, rf_waddr = HI_REG, rf_wdata = result[2*DATA_W-1:DATA_W].
  - in_ready = 1. On transfer, go to WB_LO with the new capture; else go to WB_IDLE.
- Latency: a result accepted at edge N appears on the write port during cycle N+1. For a double op, the hi write follows in cycle N+2.
- Throughput:
  - Single-word ops: 1 per cycle.
  - MULT/DIV: 1 per 2 cycles. in_ready is low exactly one cycle, during WB_LO.
- Write ports are driven combinationally from the state and capture registers. No write is issued in WB_IDLE.
- Rd == HI_REG on MULT/DIV: both writes are issued in order. The hi write is later, so the upper half is the final value.
- flags_q is updated only in WB_LO, and once per transaction. The WB_HI cycle does not change flags.
- flush:
  - Has priority over everything: next state = WB_IDLE and no capture occurs.
  - Writes in the flush cycle are still driven from the current state, because the outputs are combinational. The pending hi write of an in-progress double op is dropped.
  - in_ready stays as defined by the current state, but a transfer coinciding with flush is discarded.
- Reset mid-operation: asynchronous return to reset values; any pending lo/hi write is lost.
- Unknown/unused control encodings are treated as single-word ops.

Decomposition:
- alu_pkg (existing) supplies control_e and status_t; no changes.
- New package wb_pkg holds:
  - wb_state_e {WB_IDLE, WB_LO, WB_HI};
  - the helper function is_double(control_e), true for MULT and DIV.
- No sub-module: FSM, capture register and output mux are one module.

Test Plan:
- Reset with rst_n = 0 asynchronously mid-cycle -> rf_we = 0, in_ready = 1, flags_q = 0, busy = 0 immediately.
- Single ADD: result 0x0000_1234, rd = 3, stat.zero = 0, one-cycle valid -> next cycle rf_we = 1, waddr = 3, wdata = 0x1234; flags_q updates; then WB_IDLE.
- MULT: result 0x0001_E240, rd = 5, followed by in_valid held with ADD -> cycle 1: write R5 = 0xE240 with in_ready = 0; cycle 2: write R0 = 0x0001; the ADD is accepted at the end of cycle 2.
- DIV: result {rem 0x0002, quot 0x0007}, rd = 0 -> R0 = 0x0007, then R0 = 0x0002; final R0 = 0x0002.
- Back-to-back: AND, OR, SUB on consecutive cycles, rd = 1, 2, 3 -> three consecutive write cycles, in_ready never low.
- flush asserted during the WB_LO of a MULT -> lo write occurs, no R0 write, state WB_IDLE; a rst_n pulse during WB_HI likewise drops the hi write.
